// File: rtl/jpc_fetch_ctrl.sv
// Fetch controller: sequences jpc_pc and a single-outstanding instruction-memory port,
// buffers one fetched word and hands it to decode over a valid/ready handshake.
module jpc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_I,
  output logic [31:0] next_pc_O,
  output logic        pc_enable_O,
  output logic        imem_req_O,
  output logic [31:0] imem_addr_O,
  input  logic        imem_gnt_I,
  input  logic        imem_rvalid_I,
  input  logic [31:0] imem_rdata_I,
  input  logic        redirect_I,
  input  logic [31:0] redirect_pc_I,
  input  logic        halt_I,
  output logic        instr_valid_O,
  output logic [31:0] instr_O,
  output logic [31:0] instr_pc_O,
  input  logic        instr_ready_I
);

  typedef enum logic [2:0] {
    S_INIT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        pc_enable;
  logic        imem_req;
  logic [31:0] next_pc;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc_I & ~32'h3;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_enable  = 1'b0;
    next_pc    = 32'h0;
    imem_req   = 1'b0;
    case (state_q)
      S_INIT: begin
        pc_enable = 1'b1;
        next_pc   = RESET_PC;
        state_d   = S_REQ;
      end
      S_REQ: begin
        imem_req = !halt_I && !redirect_I;
        if (redirect_I) begin
          pc_enable = 1'b1;
          next_pc   = redirect_target;
          // A grant seen alongside a redirect still produces a response; throw it away.
          if (imem_gnt_I) state_d = S_DROP;
        end else if (imem_req && imem_gnt_I) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_I) begin
          pc_enable = 1'b1;
          next_pc   = redirect_target;
          state_d   = imem_rvalid_I ? S_REQ : S_DROP;
        end else if (imem_rvalid_I) begin
          instr_d    = imem_rdata_I;
          instr_pc_d = pc_I;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_I) begin
          pc_enable = 1'b1;
          next_pc   = redirect_target;
          state_d   = S_REQ;
        end else if (instr_ready_I) begin
          pc_enable = 1'b1;
          next_pc   = pc_I + 32'd4;
          state_d   = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_I) begin
          pc_enable = 1'b1;
          next_pc   = redirect_target;
        end
        if (imem_rvalid_I) state_d = S_REQ;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Outputs are forced quiet for the whole reset window, including its first cycle.
  assign pc_enable_O   = pc_enable && !rst;
  assign next_pc_O     = rst ? 32'h0 : next_pc;
  assign imem_req_O    = imem_req && !rst;
  assign imem_addr_O   = pc_I;
  assign instr_valid_O = (state_q == S_HOLD) && !rst;
  assign instr_O       = rst ? 32'h0 : instr_q;
  assign instr_pc_O    = rst ? 32'h0 : instr_pc_q;

endmodule

// File: tb/tb_jpc_fetch_ctrl.sv
// Bench for jpc_fetch_ctrl: emulates jpc_pc and a latency-variable memory, and checks
// every cycle against an instruction-stream scoreboard plus directed scenario checks.
module tb_jpc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_I;
  logic [31:0] next_pc_O;
  logic        pc_enable_O;
  logic        imem_req_O;
  logic [31:0] imem_addr_O;
  logic        imem_gnt_I;
  logic        imem_rvalid_I;
  logic [31:0] imem_rdata_I;
  logic        redirect_I;
  logic [31:0] redirect_pc_I;
  logic        halt_I;
  logic        instr_valid_O;
  logic [31:0] instr_O;
  logic [31:0] instr_pc_O;
  logic        instr_ready_I;

  always #5 clk = ~clk;

  jpc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc_I(pc_I), .next_pc_O(next_pc_O), .pc_enable_O(pc_enable_O),
    .imem_req_O(imem_req_O), .imem_addr_O(imem_addr_O), .imem_gnt_I(imem_gnt_I),
    .imem_rvalid_I(imem_rvalid_I), .imem_rdata_I(imem_rdata_I), .redirect_I(redirect_I),
    .redirect_pc_I(redirect_pc_I), .halt_I(halt_I), .instr_valid_O(instr_valid_O),
    .instr_O(instr_O), .instr_pc_O(instr_pc_O), .instr_ready_I(instr_ready_I)
  );

  // jpc_pc stand-in: loads next_pc on an enable pulse
  logic [31:0] pc_model;
  assign pc_I = pc_model;
  always @(posedge clk) begin
    if (rst) pc_model <= 32'h0;
    else if (pc_enable_O) pc_model <= next_pc_O;
  end

  int n_checks = 0;
  int n_errors = 0;
  int lat_min = 0;
  int lat_max = 0;
  logic [31:0] oq_addr[$];
  int          oq_cnt[$];
  logic [31:0] exp_pc;
  logic        boot_pend;
  logic        prev_hold, prev_consumed;
  logic [31:0] prev_instr, prev_ipc;
  int idle = 0, cyc = 0, last_ho = 0, n_handoff = 0, n_gnt = 0;
  logic        gap_en = 1'b0;
  logic [31:0] last_gnt_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, let memory answer, then check against the model.
  task automatic step(input logic r, input logic h, input logic rd, input logic [31:0] rpc,
                      input logic rdy, input logic gen);
    logic handoff, rd_eff;
    @(negedge clk);
    cyc++;
    rst = r; halt_I = h; redirect_I = rd; redirect_pc_I = rpc; instr_ready_I = rdy;
    imem_rvalid_I = 1'b0;
    imem_rdata_I  = $urandom;
    if (oq_addr.size() > 0) begin
      if (oq_cnt[0] == 0) begin
        imem_rvalid_I = 1'b1;
        imem_rdata_I  = mem_word(oq_addr[0]);
        void'(oq_addr.pop_front());
        void'(oq_cnt.pop_front());
      end else begin
        oq_cnt[0] = oq_cnt[0] - 1;
      end
    end
    #1 imem_gnt_I = imem_req_O && gen;
    #1;
    rd_eff  = rd && !r && !boot_pend;
    handoff = !r && instr_valid_O && rdy && !rd_eff;
    if (r) begin
      chk("rst_pc_enable", {31'h0, pc_enable_O}, 32'h0);
      chk("rst_next_pc", next_pc_O, 32'h0);
      chk("rst_req", {31'h0, imem_req_O}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid_O}, 32'h0);
      chk("rst_instr", instr_O, 32'h0);
      chk("rst_instr_pc", instr_pc_O, 32'h0);
      exp_pc = RST_PC; prev_hold = 1'b0; prev_consumed = 1'b0; idle = 0;
    end else begin
      chk("pc_enable", {31'h0, pc_enable_O}, {31'h0, (boot_pend || rd_eff || handoff)});
      if (boot_pend) chk("boot_next_pc", next_pc_O, RST_PC);
      else if (rd_eff) chk("redirect_next_pc", next_pc_O, rpc & ~32'h3);
      else if (handoff) chk("seq_next_pc", next_pc_O, exp_pc + 32'd4);
      if (handoff) begin
        chk("instr_pc", instr_pc_O, exp_pc);
        chk("instr", instr_O, mem_word(exp_pc));
        if (gap_en && n_handoff > 0) chk("handoff_gap", cyc - last_ho, 3);
        last_ho = cyc;
        n_handoff++;
        exp_pc = exp_pc + 32'd4;
      end
      if (rd_eff) exp_pc = rpc & ~32'h3;
      if (h) chk("halt_blocks_req", {31'h0, imem_req_O}, 32'h0);
      if (imem_req_O) chk("req_addr", imem_addr_O, pc_model);
      if (instr_valid_O) chk("no_req_in_hold", {31'h0, imem_req_O}, 32'h0);
      if (prev_hold) begin
        chk("hold_valid", {31'h0, instr_valid_O}, 32'h1);
        chk("hold_instr", instr_O, prev_instr);
        chk("hold_instr_pc", instr_pc_O, prev_ipc);
      end
      if (prev_consumed) chk("valid_falls", {31'h0, instr_valid_O}, 32'h0);
      if (imem_req_O && imem_gnt_I) begin
        chk("one_outstanding", oq_addr.size(), 0);
        oq_addr.push_back(imem_addr_O);
        oq_cnt.push_back($urandom_range(lat_max, lat_min));
        last_gnt_addr = imem_addr_O;
        n_gnt++;
      end
      idle = (handoff || rd_eff || boot_pend) ? 0 : idle + 1;
      if (idle > 100) begin
        chk("progress_stall", idle, 0);
        idle = 0;
      end
      prev_hold     = instr_valid_O && !handoff && !rd_eff;
      prev_consumed = instr_valid_O && (handoff || rd_eff);
      prev_instr    = instr_O;
      prev_ipc      = instr_pc_O;
    end
    boot_pend = r;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (instr_valid_O) return;
    end
    chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic wait_grant(input logic rdy);
    int g0;
    g0 = n_gnt;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 0, rdy, 1);
      if (n_gnt != g0) return;
    end
    chk("wait_grant_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; halt_I = 1'b0; redirect_I = 1'b0; redirect_pc_I = 32'h0;
    instr_ready_I = 1'b0; imem_gnt_I = 1'b0; imem_rvalid_I = 1'b0; imem_rdata_I = 32'h0;
    exp_pc = RST_PC; boot_pend = 1'b0; prev_hold = 1'b0; prev_consumed = 1'b0;
    prev_instr = 32'h0; prev_ipc = 32'h0; last_gnt_addr = 32'h0;

    // reset and boot, then back-to-back sequential fetch
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("boot_req", {31'h0, imem_req_O}, 32'h1);
    chk("boot_addr", imem_addr_O, RST_PC);
    gap_en = 1'b1;
    repeat (8) step(0, 0, 0, 0, 1, 1);
    gap_en = 1'b0;
    chk("seq_count", n_handoff, 3);

    // backpressure in HOLD
    wait_valid();
    repeat (4) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("bp_handoff", {31'h0, pc_enable_O}, 32'h1);

    // redirect while a response is outstanding
    lat_min = 3; lat_max = 3;
    wait_grant(1);
    step(0, 0, 1, 32'h103, 1, 0);
    chk("rw_next_pc", next_pc_O, 32'h100);
    for (int i = 0; i < 10 && oq_addr.size() > 0; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("drop_no_valid", {31'h0, instr_valid_O}, 32'h0);
    end
    step(0, 0, 0, 0, 1, 0);
    chk("drop_no_valid_after", {31'h0, instr_valid_O}, 32'h0);
    lat_min = 0; lat_max = 0;
    wait_grant(1);
    chk("rw_fetch_addr", last_gnt_addr, 32'h100);

    // redirect beats handoff in HOLD
    wait_valid();
    step(0, 0, 1, 32'h200, 1, 0);
    chk("rh_next_pc", next_pc_O, 32'h200);
    wait_grant(1);
    chk("rh_fetch_addr", last_gnt_addr, 32'h200);

    // halt while requesting
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1, 0);
      if (imem_req_O) break;
    end
    repeat (3) begin
      step(0, 1, 0, 0, 1, 1);
      chk("halt_req", {31'h0, imem_req_O}, 32'h0);
    end
    step(0, 0, 0, 0, 1, 1);
    chk("halt_resume", {31'h0, imem_req_O}, 32'h1);

    // wrap past the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    wait_valid();
    chk("wrap_instr_pc", instr_pc_O, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1, 0);
    chk("wrap_next_pc", next_pc_O, 32'h0);
    wait_grant(1);
    chk("wrap_fetch_addr", last_gnt_addr, 32'h0);

    // reset with a response in flight; the stale word must be ignored
    lat_min = 2; lat_max = 2;
    wait_grant(1);
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("stale_ignored", {31'h0, instr_valid_O}, 32'h0);
    lat_min = 0; lat_max = 0;
    repeat (10) step(0, 0, 0, 0, 1, 1);

    // randomized traffic
    lat_min = 0; lat_max = 3;
    repeat (3000) begin
      step(0, ($urandom % 8) == 0, ($urandom % 16) == 0, $urandom,
           ($urandom % 2) == 0, ($urandom % 4) != 0);
    end
    chk("random_progress", {31'h0, (n_handoff > 100)}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jpc_fetch_ctrl.md
# jpc_fetch_ctrl

Fetch controller that sequences the `jpc_pc` program counter and the instruction-memory port. It drives `jpc_pc`'s `next_pc_I`/`pc_enable_I`, issues one instruction fetch at a time at the current PC, buffers the returned word, and hands it to decode with a valid/ready handshake. Branch/jump redirects from execute and a halt request are handled here; `jpc_pc` only ever sees a single-cycle enable with the chosen next PC.

## Interface
- `RESET_PC`, 32'h0000_0000, vector loaded into `jpc_pc` after reset
- `clk` in 1 — single clock, all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `pc_I` in 32 — current PC from `jpc_pc.pc_O`
- `next_pc_O` out 32 — to `jpc_pc.next_pc_I`
- `pc_enable_O` out 1 — to `jpc_pc.pc_enable_I`, single-cycle pulses only
- `imem_req_O` out 1 — fetch request, held until granted
- `imem_addr_O` out 32 — fetch address, always equal to `pc_I`
- `imem_gnt_I` in 1 — request accepted this cycle
- `imem_rvalid_I` in 1 — read data valid, at least 1 cycle after grant
- `imem_rdata_I` in 32 — instruction word
- `redirect_I` in 1 — taken branch/jump from execute, single cycle
- `redirect_pc_I` in 32 — redirect target
- `halt_I` in 1 — level; blocks new fetch requests
- `instr_valid_O` out 1 — buffered instruction available
- `instr_O` out 32 — buffered instruction
- `instr_pc_O` out 32 — PC of buffered instruction
- `instr_ready_I` in 1 — decode accepts when valid & ready

## Operation
- States: INIT, REQ, WAIT, HOLD, DROP. At most one memory transaction outstanding.
- INIT: `pc_enable_O=1`, `next_pc_O=RESET_PC` for exactly one cycle, then REQ.
- REQ: `imem_req_O = !halt_I`. On `imem_gnt_I` with the request asserted, go to WAIT. Otherwise stay.
- WAIT: on `imem_rvalid_I`, latch `instr_O<=imem_rdata_I` and `instr_pc_O<=pc_I`, then go to HOLD.
- HOLD: `instr_valid_O=1`. On `instr_ready_I`, pulse `pc_enable_O` with `next_pc_O=pc_I+4` (mod 2^32, wraps FFFF_FFFC→0000_0000), then go to REQ.
- Redirect has priority over all other PC updates. In any state except INIT, `redirect_I` pulses `pc_enable_O` with `next_pc_O={redirect_pc_I[31:2],2'b00}`.
  - In REQ without grant, stay in REQ; the request is withdrawn for one cycle.
  - In REQ with grant, go to DROP.
  - In WAIT without rvalid, go to DROP.
  - In WAIT with rvalid, discard the word and go to REQ.
  - In HOLD, drop the buffered instruction, even if `instr_ready_I` is high that cycle, and go to REQ.
  - In DROP, stay in DROP.
- Redirect during INIT is ignored.
- DROP: the next `imem_rvalid_I` is discarded, then go to REQ.
- `halt_I` does not affect redirect, response capture, or handoff.
- `imem_rvalid_I` in REQ/HOLD/INIT is a protocol error; it is ignored and does not change state.

## Timing
- During `rst`: state←INIT. All outputs are 0: `pc_enable_O`, `next_pc_O`, `imem_req_O`, `instr_valid_O`, `instr_O`, `instr_pc_O`.
- First cycle after `rst` deasserts: INIT pulse. `pc_I=RESET_PC` one cycle later.
- `pc_enable_O` is never high two consecutive cycles except for back-to-back redirects.
- Best case throughput is 1 instruction per 3 cycles:
  - REQ with grant.
  - WAIT with rvalid on the next cycle.
  - HOLD with ready.
- `instr_valid_O` rises the cycle after rvalid. It falls the cycle after handoff or redirect.
- `instr_O` and `instr_pc_O` are stable while `instr_valid_O` is high.
- `rst` mid-transaction returns to INIT. Any later in-flight rvalid lands in INIT/REQ and is ignored.

## Test plan
- Reset/boot: `RESET_PC`=32'h80, `rst` high for 2 cycles. Expect all outputs 0 during reset, one `pc_enable_O` pulse with `next_pc_O`=80, then `imem_req_O` with `imem_addr_O`=80.
- Sequential fetch: memory grants immediately, rvalid +1 cycle, ready always high. Expect instructions at PCs 80, 84, 88, each `instr_valid_O` 3 cycles apart, `instr_O` matching memory.
- Backpressure: hold `instr_ready_I` low 4 cycles in HOLD. Expect `instr_valid_O`/`instr_O` steady and no `pc_enable_O` pulse or request. Handoff on the first ready cycle.
- Redirect in WAIT: `redirect_I` with target 32'h103 while a response is outstanding.
  - Expect `next_pc_O`=100 with a pulse.
  - Expect the late rvalid discarded and no `instr_valid_O`.
  - Expect the next request at 100.
- Redirect vs handoff: redirect to 200 in HOLD with `instr_ready_I`=1. Expect a single pulse with `next_pc_O`=200, not pc+4, and the next fetch at 200.
- Halt and wrap: `halt_I` high in REQ for 3 cycles, expect `imem_req_O`=0 and resume after. Redirect to FFFF_FFFC and hand off; expect `next_pc_O`=0000_0000.
